// File: rtl/pulse_stretcher.sv
//------------------------------------------------------------------------------
// Module   : pulse_stretcher
// Purpose  : Stretches single-cycle event strobes into fixed-length LED pulses
//            separated by a fixed low gap. Late events are queued and replayed.
// Option   : PULSE_STRETCHER_RETRIGGER_EN - a pulse during HIGH reloads the window
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4000000,
  parameter int GAP_CYCLES  = 2000000,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int TMR_MAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]  C_HIGH_LOAD = TMR_W'(HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0]  C_GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  C_TMR_ZERO  = '0;
  localparam logic [TMR_W-1:0]  C_TMR_ONE   = TMR_W'(1);
  localparam logic [PEND_W-1:0] C_PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] C_PEND_ZERO = '0;
  localparam logic [PEND_W-1:0] C_PEND_ONE  = PEND_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic [TMR_W-1:0]   timer_q,    timer_d;
  logic [PEND_W-1:0]  pending_q,  pending_d;
  logic               overflow_q, overflow_d;
  logic               led_out_q,  led_out_d;
  logic               busy_q,     busy_d;

  logic w_start;
  logic w_queue;
  logic w_consume;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    w_start    = 1'b0;
    w_queue    = 1'b0;
    w_consume  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        w_start = 1'b1;
      end
      ST_HIGH: begin
        if (timer_q == C_TMR_ZERO) begin
          state_d = ST_GAP;
          timer_d = C_GAP_LOAD;
        end else begin
          timer_d = timer_q - C_TMR_ONE;
        end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        // A fresh event restarts the window and never touches the queue.
        if (pulse_in) begin
          state_d = ST_HIGH;
          timer_d = C_HIGH_LOAD;
        end
`else
        w_queue = pulse_in;
`endif
      end
      ST_GAP: begin
        if (timer_q == C_TMR_ZERO) begin
          w_start = 1'b1;
        end else begin
          timer_d = timer_q - C_TMR_ONE;
          w_queue = pulse_in;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = C_TMR_ZERO;
      end
    endcase

    // Queued events take priority so replay order matches arrival order.
    if (w_start) begin
      if (pending_q != C_PEND_ZERO) begin
        state_d   = ST_HIGH;
        timer_d   = C_HIGH_LOAD;
        w_consume = 1'b1;
        w_queue   = pulse_in;
      end else if (pulse_in) begin
        state_d = ST_HIGH;
        timer_d = C_HIGH_LOAD;
      end else begin
        state_d = ST_IDLE;
        timer_d = C_TMR_ZERO;
      end
    end

    case ({w_queue, w_consume})
      2'b10: begin
        if (pending_q == C_PEND_MAX) begin
          overflow_d = 1'b1;
        end else begin
          pending_d = pending_q + C_PEND_ONE;
        end
      end
      2'b01:   pending_d = pending_q - C_PEND_ONE;
      default: pending_d = pending_q;
    endcase

    led_out_d = (state_d == ST_HIGH);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= C_TMR_ZERO;
      pending_q  <= C_PEND_ZERO;
      overflow_q <= 1'b0;
      led_out_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      led_out_q  <= led_out_d;
      busy_q     <= busy_d;
    end
  end

  assign led_out  = led_out_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire
